// File: rtl/seq_num_rob_pkg.sv
// Shared types and helpers for the sequence-number reorder buffer.
package seq_num_rob_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned WADDR_W = 5;
    localparam int unsigned WDATA_W = 32;

    typedef struct packed {
        logic               valid;
        logic               done;
        logic [PC_W-1:0]    pc;
        logic [WADDR_W-1:0] waddr;
        logic [WDATA_W-1:0] wdata;
        logic               wen;
    } t_rob_entry;

    // Entry index is the low bits of the sequence number; depth is a power of two.
    function automatic int unsigned rob_idx(input int unsigned seq_num, input int unsigned depth);
        return seq_num & (depth - 1);
    endfunction

endpackage

// File: rtl/seq_num_rob_if.sv
// Dispatch/complete/commit bus of the reorder buffer; master = pipeline side, slave = ROB.
interface seq_num_rob_if
    import seq_num_rob_pkg::*;
#(
    parameter int unsigned p_seq_num_bits = 5
);
    logic                      alloc_val;
    logic                      alloc_rdy;
    logic [p_seq_num_bits-1:0] alloc_seq_num;

    logic                      cmpl_val;
    logic                      cmpl_rdy;
    logic [p_seq_num_bits-1:0] cmpl_seq_num;
    logic [PC_W-1:0]           cmpl_pc;
    logic [WADDR_W-1:0]        cmpl_waddr;
    logic [WDATA_W-1:0]        cmpl_wdata;
    logic                      cmpl_wen;

    logic                      commit_val;
    logic [PC_W-1:0]           commit_pc;
    logic [p_seq_num_bits-1:0] commit_seq_num;
    logic [WADDR_W-1:0]        commit_waddr;
    logic [WDATA_W-1:0]        commit_wdata;
    logic                      commit_wen;

    logic [p_seq_num_bits-1:0] head_seq_num;

    modport master (
        output alloc_val, cmpl_val, cmpl_seq_num, cmpl_pc, cmpl_waddr, cmpl_wdata, cmpl_wen,
        input  alloc_rdy, alloc_seq_num, cmpl_rdy,
        input  commit_val, commit_pc, commit_seq_num, commit_waddr, commit_wdata, commit_wen,
        input  head_seq_num
    );

    modport slave (
        input  alloc_val, cmpl_val, cmpl_seq_num, cmpl_pc, cmpl_waddr, cmpl_wdata, cmpl_wen,
        output alloc_rdy, alloc_seq_num, cmpl_rdy,
        output commit_val, commit_pc, commit_seq_num, commit_waddr, commit_wdata, commit_wen,
        output head_seq_num
    );
endinterface

// File: rtl/seq_num_rob_storage.sv
// ROB entry array: allocate, complete and release write ports; async head and lookup reads.
module seq_num_rob_storage
    import seq_num_rob_pkg::*;
#(
    parameter int unsigned p_rob_depth = 4,
    localparam int unsigned IDX_W      = $clog2(p_rob_depth)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_en,
    input  logic [IDX_W-1:0] alloc_idx,
    input  logic             cmpl_en,
    input  logic [IDX_W-1:0] cmpl_idx,
    input  t_rob_entry       cmpl_entry,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx,
    input  logic [IDX_W-1:0] head_idx,
    output t_rob_entry       head_entry,
    output logic             cmpl_valid,
    output logic             cmpl_done
);
    t_rob_entry entries [p_rob_depth];

    // Port targets never collide: tail is free, completions hit not-done entries, release hits a done head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entries <= '{default: '0};
        end else begin
            if (alloc_en) entries[alloc_idx] <= '{valid: 1'b1, default: '0};
            if (cmpl_en)  entries[cmpl_idx]  <= cmpl_entry;
            if (clr_en)   entries[clr_idx]   <= '0;
        end
    end

    assign head_entry = entries[head_idx];
    assign cmpl_valid = entries[cmpl_idx].valid;
    assign cmpl_done  = entries[cmpl_idx].done;

endmodule

// File: rtl/seq_num_rob.sv
// Sequence-number reorder buffer: in-order grant, out-of-order completion, in-order commit.
// Optional SEQ_NUM_ROB_COMMIT_BYPASS_EN commits a head completion in the same cycle.
module seq_num_rob
    import seq_num_rob_pkg::*;
#(
    parameter int unsigned p_seq_num_bits = 5,
    parameter int unsigned p_rob_depth    = 4
) (
    input  logic         clk,
    input  logic         rst,
    seq_num_rob_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(p_rob_depth);
    localparam int unsigned CNT_W = $clog2(p_rob_depth + 1);

    logic [p_seq_num_bits-1:0] head;
    logic [p_seq_num_bits-1:0] tail;
    logic [CNT_W-1:0]          count;
    logic [IDX_W-1:0]          head_idx;
    logic [IDX_W-1:0]          tail_idx;
    logic [IDX_W-1:0]          cmpl_idx;
    t_rob_entry                head_entry;
    t_rob_entry                cmpl_entry;
    t_rob_entry                commit_src;
    logic                      alloc_rdy;
    logic                      cmpl_valid;
    logic                      cmpl_done;
    logic                      cmpl_ok;
    logic                      bypass_c;
    logic                      cmpl_we;
    logic                      do_alloc;
    logic                      do_commit;

    assign head_idx = IDX_W'(rob_idx(32'(head), p_rob_depth));
    assign tail_idx = IDX_W'(rob_idx(32'(tail), p_rob_depth));
    assign cmpl_idx = IDX_W'(rob_idx(32'(bus.cmpl_seq_num), p_rob_depth));

    assign alloc_rdy = (count != CNT_W'(p_rob_depth));
    assign do_alloc  = bus.alloc_val && alloc_rdy;
    assign cmpl_ok   = bus.cmpl_val && cmpl_valid && !cmpl_done;

`ifdef SEQ_NUM_ROB_COMMIT_BYPASS_EN
    assign bypass_c = cmpl_ok && (bus.cmpl_seq_num == head);
`else
    assign bypass_c = 1'b0;
`endif

    // A bypassed completion is retired straight from the inputs and never written.
    assign cmpl_we    = cmpl_ok && !bypass_c;
    assign do_commit  = (head_entry.valid && head_entry.done) || bypass_c;
    assign cmpl_entry = '{valid: 1'b1, done: 1'b1, pc: bus.cmpl_pc, waddr: bus.cmpl_waddr,
                          wdata: bus.cmpl_wdata, wen: bus.cmpl_wen};
    assign commit_src = bypass_c ? cmpl_entry : head_entry;

    seq_num_rob_storage #(
        .p_rob_depth (p_rob_depth)
    ) u_storage (
        .clk        (clk),
        .rst        (rst),
        .alloc_en   (do_alloc),
        .alloc_idx  (tail_idx),
        .cmpl_en    (cmpl_we),
        .cmpl_idx   (cmpl_idx),
        .cmpl_entry (cmpl_entry),
        .clr_en     (do_commit),
        .clr_idx    (head_idx),
        .head_idx   (head_idx),
        .head_entry (head_entry),
        .cmpl_valid (cmpl_valid),
        .cmpl_done  (cmpl_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_alloc)  tail <= tail + p_seq_num_bits'(1);
            if (do_commit) head <= head + p_seq_num_bits'(1);
            unique case ({do_alloc, do_commit})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.alloc_rdy      = alloc_rdy;
    assign bus.alloc_seq_num  = tail;
    assign bus.cmpl_rdy       = 1'b1;
    assign bus.head_seq_num   = head;
    assign bus.commit_val     = do_commit;
    assign bus.commit_seq_num = head;
    assign bus.commit_pc      = commit_src.pc;
    assign bus.commit_waddr   = commit_src.waddr;
    assign bus.commit_wdata   = commit_src.wdata;
    assign bus.commit_wen     = commit_src.wen;

`ifndef SYNTHESIS
    // Completions for free or already-done entries are dropped.
    always_ff @(posedge clk) begin
        if (rst && bus.cmpl_val) begin
            assert (cmpl_ok)
            else $error("seq_num_rob: ignored completion for seq %0d", bus.cmpl_seq_num);
        end
    end
`endif

endmodule
